// File: rtl/inv_park_if.sv
// Operand/result bundle for the inverse Park transform block.
interface inv_park_if #(
  parameter int D_WIDTH = 18
);
  logic signed [D_WIDTH-1:0] d;
  logic signed [D_WIDTH-1:0] q;
  logic signed [D_WIDTH-1:0] sin;
  logic signed [D_WIDTH-1:0] cos;
  logic                      start;
  logic signed [D_WIDTH-1:0] alpha;
  logic signed [D_WIDTH-1:0] beta;
  logic                      done;
  logic                      busy;
  logic                      sat;

  modport master (
    output d, q, sin, cos, start,
    input  alpha, beta, done, busy, sat
  );

  modport slave (
    input  d, q, sin, cos, start,
    output alpha, beta, done, busy, sat
  );
endinterface

// File: rtl/inv_park.sv
// Inverse Park transform: alpha = d*cos - q*sin, beta = d*sin + q*cos,
// one shared signed multiplier stepped over four cycles, saturated outputs.
module inv_park #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15
) (
  input logic       clk,
  input logic       rstb,
  inv_park_if.slave bus
);

  localparam int ACC_W = D_WIDTH + 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] M0   = 3'd1;
  localparam logic [2:0] M1   = 3'd2;
  localparam logic [2:0] M2   = 3'd3;
  localparam logic [2:0] M3   = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  logic [2:0]                state;
  logic signed [D_WIDTH-1:0] d_r, q_r, sin_r, cos_r;
  logic signed [D_WIDTH-1:0] mul_a, mul_b;
  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_a, acc_b;
  logic signed [D_WIDTH-1:0] alpha_r, beta_r;
  logic                      sat_r, done_r;

  // True when the accumulator lies outside the D_WIDTH signed range.
  function automatic logic ovf(input logic signed [ACC_W-1:0] v);
    return !((&v[ACC_W-1:D_WIDTH-1]) || !(|v[ACC_W-1:D_WIDTH-1]));
  endfunction

  function automatic logic signed [D_WIDTH-1:0] clip(input logic signed [ACC_W-1:0] v);
    if (!ovf(v))
      return v[D_WIDTH-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(D_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(D_WIDTH-1){1'b1}}};
  endfunction

  // Operand select for the single multiplier, one product per M-state.
  always_comb begin
    mul_a = d_r;
    mul_b = cos_r;
    case (state)
      M1: begin mul_a = q_r; mul_b = sin_r; end
      M2: begin mul_a = d_r; mul_b = sin_r; end
      M3: begin mul_a = q_r; mul_b = cos_r; end
      default: begin mul_a = d_r; mul_b = cos_r; end
    endcase
  end

  assign prod = mul_a * mul_b;
  assign term = ACC_W'(prod >>> Q_BITS);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      d_r     <= '0;
      q_r     <= '0;
      sin_r   <= '0;
      cos_r   <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
      alpha_r <= '0;
      beta_r  <= '0;
      sat_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            d_r   <= bus.d;
            q_r   <= bus.q;
            sin_r <= bus.sin;
            cos_r <= bus.cos;
            state <= M0;
          end
        end
        M0: begin acc_a <= term;         state <= M1; end
        M1: begin acc_a <= acc_a - term; state <= M2; end
        M2: begin acc_b <= term;         state <= M3; end
        M3: begin acc_b <= acc_b + term; state <= OUT; end
        OUT: begin
          alpha_r <= clip(acc_a);
          beta_r  <= clip(acc_b);
          sat_r   <= ovf(acc_a) | ovf(acc_b);
          done_r  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.alpha = alpha_r;
  assign bus.beta  = beta_r;
  assign bus.sat   = sat_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_inv_park.sv
// Bench for inv_park: timeline model of accept/done plus literal result pins.
module tb_inv_park;

  localparam int  DW   = 18;
  localparam int  QB   = 15;
  localparam int  MAXV = 131071;
  localparam int  MINV = -131072;

  logic clk = 1'b0;
  logic rstb;
  logic chk_on = 1'b0;

  inv_park_if #(.D_WIDTH(DW)) bus ();

  inv_park #(.D_WIDTH(DW), .Q_BITS(QB)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Pins requested by stimulus for the result of the next accepted start.
  bit pin_en;
  int pin_a, pin_b, pin_s;

  // Model: results from plain wide arithmetic; timing from the accept edge.
  function automatic longint raw_a(input int d, input int q, input int s, input int c);
    return ((longint'(d) * longint'(c)) >>> QB) - ((longint'(q) * longint'(s)) >>> QB);
  endfunction

  function automatic longint raw_b(input int d, input int q, input int s, input int c);
    return ((longint'(d) * longint'(s)) >>> QB) + ((longint'(q) * longint'(c)) >>> QB);
  endfunction

  function automatic int clip(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
  endfunction

  function automatic int ovf(input longint v);
    return (v > MAXV || v < MINV) ? 1 : 0;
  endfunction

  int edge_n, acc_edge;
  int pend_a, pend_b, pend_s;
  bit pend_pin_en;
  int pend_pin_a, pend_pin_b, pend_pin_s;
  int exp_alpha, exp_beta, exp_sat;
  bit cur_pin_en;
  int cur_pin_a, cur_pin_b, cur_pin_s;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      edge_n     <= 0;
      acc_edge   <= -100;
      exp_alpha  <= 0;
      exp_beta   <= 0;
      exp_sat    <= 0;
      cur_pin_en <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (!(edge_n + 1 >= acc_edge && edge_n + 1 <= acc_edge + 5) && bus.start) begin
        acc_edge    <= edge_n + 1;
        pend_a      <= clip(raw_a(int'(bus.d), int'(bus.q), int'(bus.sin), int'(bus.cos)));
        pend_b      <= clip(raw_b(int'(bus.d), int'(bus.q), int'(bus.sin), int'(bus.cos)));
        pend_s      <= ovf(raw_a(int'(bus.d), int'(bus.q), int'(bus.sin), int'(bus.cos))) |
                       ovf(raw_b(int'(bus.d), int'(bus.q), int'(bus.sin), int'(bus.cos)));
        pend_pin_en <= pin_en;
        pend_pin_a  <= pin_a;
        pend_pin_b  <= pin_b;
        pend_pin_s  <= pin_s;
      end
      if (edge_n + 1 == acc_edge + 5) begin
        exp_alpha  <= pend_a;
        exp_beta   <= pend_b;
        exp_sat    <= pend_s;
        cur_pin_en <= pend_pin_en;
        cur_pin_a  <= pend_pin_a;
        cur_pin_b  <= pend_pin_b;
        cur_pin_s  <= pend_pin_s;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("done",  int'(bus.done),  (edge_n == acc_edge + 5) ? 1 : 0);
      chk("busy",  int'(bus.busy),  (edge_n >= acc_edge && edge_n <= acc_edge + 4) ? 1 : 0);
      chk("alpha", int'(bus.alpha), exp_alpha);
      chk("beta",  int'(bus.beta),  exp_beta);
      chk("sat",   int'(bus.sat),   exp_sat);
      if (edge_n == acc_edge + 5 && cur_pin_en) begin
        chk("pin_alpha", int'(bus.alpha), cur_pin_a);
        chk("pin_beta",  int'(bus.beta),  cur_pin_b);
        chk("pin_sat",   int'(bus.sat),   cur_pin_s);
      end
    end
  end

  task automatic ops(input int dd, input int qq, input int ss, input int cc);
    bus.d   = DW'(dd);
    bus.q   = DW'(qq);
    bus.sin = DW'(ss);
    bus.cos = DW'(cc);
  endtask

  task automatic pin(input bit en, input int a, input int b, input int s);
    pin_en = en;
    pin_a  = a;
    pin_b  = b;
    pin_s  = s;
  endtask

  task automatic scramble();
    ops(int'($urandom_range(0, 60000)) - 30000, int'($urandom_range(0, 60000)) - 30000,
        int'($urandom_range(0, 60000)) - 30000, int'($urandom_range(0, 60000)) - 30000);
  endtask

  task automatic run(input int dd, input int qq, input int ss, input int cc,
                     input bit en, input int a, input int b, input int s);
    @(posedge clk); #2;
    ops(dd, qq, ss, cc);
    pin(en, a, b, s);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    pin(1'b0, 0, 0, 0);
    scramble();
    repeat (5) @(posedge clk);
  endtask

  int bd[4] = '{1000, -5000, 77777, -131072};
  int bq[4] = '{-2000, 12345, -99999, 131071};
  int bs[4] = '{23170, -32768, 5000, 32767};
  int bc[4] = '{23170, 0, -30000, -1};

  initial begin
    rstb = 1'b1;
    bus.start = 1'b0;
    ops(0, 0, 0, 0);
    pin(1'b0, 0, 0, 0);
    #1 rstb = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rstb = 1'b1;

    run(16384, -8192, 0, 32767,          1'b1, 16383, -8192, 0);
    run(16384, 8192, 32767, 0,           1'b1, -8191, 16383, 0);
    run(131071, -131072, 32767, 32767,   1'b1, 131071, -1, 1);
    run(-131072, -131072, -32768, 32767, 1'b1, -131072, 4, 1);
    run(-20000, 30000, 23170, -23170,    1'b0, 0, 0, 0);

    // Second start during M1 with new operands must be ignored.
    @(posedge clk); #2;
    ops(16384, 8192, 32767, 0);
    pin(1'b1, -8191, 16383, 0);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    pin(1'b0, 0, 0, 0);
    scramble();
    @(posedge clk); #2;
    ops(1000, 2000, 3000, 4000);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);

    // Start held high with operands changing every cycle.
    @(posedge clk); #2;
    bus.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      ops(bd[i % 4], bq[i % 4], bs[i % 4], bc[i % 4]);
      @(posedge clk); #2;
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);

    // Reset asserted while in M2, then a quiet period with no start.
    @(posedge clk); #2;
    ops(16384, -8192, 0, 32767);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #2 rstb = 1'b1;
    repeat (8) @(posedge clk);

    run(16384, -8192, 0, 32767, 1'b1, 16383, -8192, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
